daq_arbiter: RTL and testbench

//   Shares the single DAQ output stream between NREQ sensor blocks (as5311 and similar) that use the
//   daq_req/daq_grant/daq_valid/daq_end handshake. Grants round-robin, and only when the downstream
//   DAQ FIFO can absorb a full packet, since requesters cannot be stalled once granted. Forwards the

---
 rtl/daq_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_daq_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_arbiter.sv
// daq_arbiter: round-robin owner of the shared DAQ output stream.
// A requester is granted only when the downstream FIFO can absorb a full
// packet; the owner's words are forwarded with one cycle of latency, hung
// transfers are aborted by a timer, and words from non-owners are flagged.
module daq_arbiter #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned PKT_MAX   = 2,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned FREE_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    output logic [NREQ-1:0]        grant,
    input  logic [NREQ*32-1:0]     in_data,
    input  logic [NREQ-1:0]        in_valid,
    input  logic [NREQ-1:0]        in_end,
    input  logic [FREE_BITS-1:0]   fifo_free,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    output logic                   out_end,
    output logic                   out_abort,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_stray,
    input  logic                   err_clear
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = (NREQ < 2) ? 1 : $clog2(NREQ);
    localparam int unsigned TMR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          TMO_EN = (TIMEOUT != 0);

    localparam logic [FREE_BITS-1:0] PKT_MAX_F = FREE_BITS'(PKT_MAX);
    localparam logic [TMR_W-1:0]     TMR_LOAD  = TMR_W'(TIMEOUT);
    localparam logic [PTR_W-1:0]     LAST_IDX  = PTR_W'(NREQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic [NREQ-1:0]     grant_d;
    logic [DATA_W-1:0]   out_data_d;
    logic                out_valid_d;
    logic                out_end_d;
    logic                out_abort_d;
    logic                busy_d;
    logic                err_timeout_d;
    logic                err_stray_d;

    logic                owner_valid;
    logic                owner_end;
    logic [DATA_W-1:0]   owner_data;
    logic [NREQ-1:0]     owner_mask;
    logic                stray_c;

    logic                pick_found;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    next_ptr;

    // Select the current owner's handshake signals from the flat buses.
    always_comb begin
        owner_valid = 1'b0;
        owner_end   = 1'b0;
        owner_data  = '0;
        owner_mask  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == PTR_W'(i)) begin
                owner_valid   = in_valid[i];
                owner_end     = in_end[i];
                owner_data    = in_data[DATA_W*i +: DATA_W];
                owner_mask[i] = 1'b1;
            end
        end
    end

    // Any valid while idle, or from a non-owner during a transfer, is dropped and flagged.
    always_comb begin
        stray_c = 1'b0;
        if (state_q == IDLE) begin
            stray_c = |in_valid;
        end else begin
            stray_c = |(in_valid & ~owner_mask);
        end
    end

    // Round-robin pick: first requester at or after ptr, then wrap to the ones below it.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req[i] && (PTR_W'(i) >= ptr_q)) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_found && req[i] && (PTR_W'(i) < ptr_q)) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(i);
            end
        end
    end

    // Pointer value after the current owner, wrapping at the last requester.
    always_comb begin
        next_ptr = '0;
        if (owner_q != LAST_IDX) begin
            next_ptr = owner_q + 1'b1;
        end
    end

    // Next-state and next-output logic for the grant/transfer FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        timer_d       = timer_q;
        grant_d       = '0;
        out_data_d    = out_data;
        out_valid_d   = 1'b0;
        out_end_d     = 1'b0;
        out_abort_d   = 1'b0;
        err_timeout_d = err_timeout & ~err_clear;
        err_stray_d   = (err_stray & ~err_clear) | stray_c;

        case (state_q)
            IDLE: begin
                if (pick_found && (fifo_free >= PKT_MAX_F)) begin
                    grant_d  = NREQ'(1) << pick_idx;
                    owner_d  = pick_idx;
                    timer_d  = TMR_LOAD;
                    state_d  = XFER;
                end
            end
            XFER: begin
                // Timer saturates at zero so a word in the last slot buys exactly one more cycle.
                if (TMO_EN && (timer_q != '0)) begin
                    timer_d = timer_q - 1'b1;
                end
                if (owner_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = owner_data;
                    out_end_d   = owner_end;
                    if (owner_end) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr;
                    end
                end else if (TMO_EN && (timer_q <= TMR_W'(1))) begin
                    out_abort_d   = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                    ptr_d         = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == XFER);
    end

    // State and registered outputs; reset drops any packet in flight silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            timer_q     <= '0;
            grant       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_end     <= 1'b0;
            out_abort   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_stray   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            timer_q     <= timer_d;
            grant       <= grant_d;
            out_data    <= out_data_d;
            out_valid   <= out_valid_d;
            out_end     <= out_end_d;
            out_abort   <= out_abort_d;
            busy        <= busy_d;
            err_timeout <= err_timeout_d;
            err_stray   <= err_stray_d;
        end
    end

endmodule

// File: tb/tb_daq_arbiter.sv
// tb_daq_arbiter: directed scenarios for the DAQ stream arbiter.
module tb_daq_arbiter;

    localparam int unsigned NREQ = 3;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   grant;
    logic [NREQ*32-1:0] in_data;
    logic [NREQ-1:0]   in_valid;
    logic [NREQ-1:0]   in_end;
    logic [7:0]        fifo_free;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_end;
    logic              out_abort;
    logic              busy;
    logic              err_timeout;
    logic              err_stray;
    logic              err_clear;

    int n_checks = 0;
    int n_fail   = 0;

    daq_arbiter #(
        .NREQ      (NREQ),
        .PKT_MAX   (2),
        .TIMEOUT   (8),
        .FREE_BITS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_end      (in_end),
        .fifo_free   (fifo_free),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_end     (out_end),
        .out_abort   (out_abort),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_stray   (err_stray),
        .err_clear   (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req       = '0;
        in_data   = '0;
        in_valid  = '0;
        in_end    = '0;
        err_clear = 1'b0;
        fifo_free = 8'd16;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req       = '0;
        in_data   = '0;
        in_valid  = '0;
        in_end    = '0;
        err_clear = 1'b0;
        fifo_free = 8'd16;
        #2;
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b expected 000", grant); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_end !== 1'b0) begin n_fail++; $display("FAIL reset_out_end: got %b expected 0", out_end); end
        n_checks++; if (out_abort !== 1'b0) begin n_fail++; $display("FAIL reset_out_abort: got %b expected 0", out_abort); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err_timeout: got %b expected 0", err_timeout); end
        n_checks++; if (err_stray !== 1'b0) begin n_fail++; $display("FAIL reset_err_stray: got %b expected 0", err_stray); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        apply_reset();
        req = 3'b110;
        step();
        n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL basic_grant: got %b expected 010", grant); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        req = '0;
        in_valid[1] = 1'b1; in_end[1] = 1'b0; in_data[63:32] = 32'h0000000A;
        step();
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL basic_grant_pulse: got %b expected 000", grant); end
        n_checks++; if ({out_valid, out_end, out_data} !== {1'b1, 1'b0, 32'h0000000A})
            begin n_fail++; $display("FAIL basic_word0: got v=%b e=%b d=%h expected v=1 e=0 d=0000000a", out_valid, out_end, out_data); end
        in_end[1] = 1'b1; in_data[63:32] = 32'h0000000B;
        step();
        n_checks++; if ({out_valid, out_end, out_data} !== {1'b1, 1'b1, 32'h0000000B})
            begin n_fail++; $display("FAIL basic_word1: got v=%b e=%b d=%h expected v=1 e=1 d=0000000b", out_valid, out_end, out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
        in_valid = '0; in_end = '0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %b expected 0", out_valid); end
        n_checks++; if (err_stray !== 1'b0) begin n_fail++; $display("FAIL basic_no_stray: got %b expected 0", err_stray); end
    endtask

    task automatic test_round_robin();
        int          exp_order[5];
        logic [2:0]  exp_grant;
        bit          found;
        int          idx;
        exp_order = '{0, 1, 2, 0, 1};
        apply_reset();
        req = 3'b111;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int w = 0; w < 10 && !found; w++) begin
                step();
                if (grant !== 3'b000) found = 1'b1;
            end
            idx       = exp_order[k];
            exp_grant = 3'(1) << idx;
            n_checks++;
            if (!found) begin
                n_fail++; $display("FAIL rr_grant_wait[%0d]: got no grant expected %b", k, exp_grant);
            end else if (grant !== exp_grant) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, grant, exp_grant);
            end
            in_valid[idx] = 1'b1; in_end[idx] = 1'b0; in_data[32*idx +: 32] = 32'h100 + 32'(k);
            step();
            n_checks++; if (grant !== 3'b000 || out_valid !== 1'b1 || out_data !== 32'h100 + 32'(k))
                begin n_fail++; $display("FAIL rr_word0[%0d]: got g=%b v=%b d=%h expected g=000 v=1 d=%h", k, grant, out_valid, out_data, 32'h100 + 32'(k)); end
            in_end[idx] = 1'b1; in_data[32*idx +: 32] = 32'h200 + 32'(k);
            step();
            n_checks++; if (grant !== 3'b000 || out_end !== 1'b1 || out_data !== 32'h200 + 32'(k))
                begin n_fail++; $display("FAIL rr_word1[%0d]: got g=%b e=%b d=%h expected g=000 e=1 d=%h", k, grant, out_end, out_data, 32'h200 + 32'(k)); end
            in_valid = '0; in_end = '0;
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_fifo_gate();
        bit saw_grant;
        apply_reset();
        fifo_free = 8'd1;
        req = 3'b001;
        saw_grant = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (grant !== 3'b000) saw_grant = 1'b1;
        end
        n_checks++; if (saw_grant) begin n_fail++; $display("FAIL fifo_gate_hold: got grant=1 expected none with fifo_free=1"); end
        fifo_free = 8'd2;
        step();
        n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL fifo_gate_grant: got %b expected 001", grant); end
        req = '0;
        fifo_free = 8'd0;
        in_valid[0] = 1'b1; in_end[0] = 1'b1; in_data[31:0] = 32'h0000C0DE;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_end !== 1'b1 || out_data !== 32'h0000C0DE)
            begin n_fail++; $display("FAIL fifo_gate_xfer: got v=%b e=%b d=%h expected v=1 e=1 d=0000c0de", out_valid, out_end, out_data); end
        in_valid = '0; in_end = '0;
        fifo_free = 8'd16;
        step();
    endtask

    task automatic test_timeout();
        bit early_abort;
        apply_reset();
        req = 3'b011;
        step();
        n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL tmo_grant0: got %b expected 001", grant); end
        req = 3'b010;
        early_abort = 1'b0;
        for (int c = 1; c < 8; c++) begin
            step();
            if (out_abort !== 1'b0 || busy !== 1'b1) early_abort = 1'b1;
        end
        n_checks++; if (early_abort) begin n_fail++; $display("FAIL tmo_early: got abort or idle before 8 cycles expected busy and no abort"); end
        step();
        n_checks++; if (out_abort !== 1'b1) begin n_fail++; $display("FAIL tmo_abort: got %b expected 1", out_abort); end
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", err_timeout); end
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_state: got v=%b busy=%b expected 0 0", out_valid, busy); end
        step();
        n_checks++; if (grant !== 3'b010 || out_abort !== 1'b0)
            begin n_fail++; $display("FAIL tmo_next_grant: got g=%b abort=%b expected g=010 abort=0", grant, out_abort); end
        req = '0;
        in_valid[1] = 1'b1; in_end[1] = 1'b1; in_data[63:32] = 32'h00000055;
        step();
        n_checks++; if (out_end !== 1'b1 || out_data !== 32'h00000055 || err_timeout !== 1'b1)
            begin n_fail++; $display("FAIL tmo_after: got e=%b d=%h errt=%b expected e=1 d=00000055 errt=1", out_end, out_data, err_timeout); end
        in_valid = '0; in_end = '0;
        step();
    endtask

    task automatic test_stray();
        apply_reset();
        req = 3'b001;
        step();
        n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL stray_grant: got %b expected 001", grant); end
        req = '0;
        in_valid[2] = 1'b1; in_data[95:64] = 32'h0000DEAD;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stray_dropped: got %b expected 0", out_valid); end
        n_checks++; if (err_stray !== 1'b1) begin n_fail++; $display("FAIL stray_flag: got %b expected 1", err_stray); end
        in_valid = '0;
        err_clear = 1'b1;
        step();
        n_checks++; if (err_stray !== 1'b0) begin n_fail++; $display("FAIL stray_clear: got %b expected 0", err_stray); end
        in_valid[2] = 1'b1;
        step();
        n_checks++; if (err_stray !== 1'b1) begin n_fail++; $display("FAIL stray_set_wins: got %b expected 1", err_stray); end
        err_clear = 1'b0;
        in_valid = '0;
        in_valid[0] = 1'b1; in_end[0] = 1'b1; in_data[31:0] = 32'h00000077;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_end !== 1'b1 || out_data !== 32'h00000077)
            begin n_fail++; $display("FAIL stray_owner_word: got v=%b e=%b d=%h expected v=1 e=1 d=00000077", out_valid, out_end, out_data); end
        in_valid = '0; in_end = '0;
        err_clear = 1'b1;
        step();
        n_checks++; if (err_stray !== 1'b0) begin n_fail++; $display("FAIL stray_clear2: got %b expected 0", err_stray); end
        err_clear = 1'b0;
        in_valid[0] = 1'b1;
        step();
        n_checks++; if (err_stray !== 1'b1 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL stray_idle: got err=%b v=%b expected err=1 v=0", err_stray, out_valid); end
        in_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 3'b010;
        step();
        n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rmid_grant_a: got %b expected 010", grant); end
        req = '0;
        in_valid[1] = 1'b1; in_end[1] = 1'b1; in_data[63:32] = 32'h00000011;
        step();
        in_valid = '0; in_end = '0;
        req = 3'b010;
        step();
        n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rmid_grant_b: got %b expected 010", grant); end
        req = '0;
        in_valid[1] = 1'b1; in_end[1] = 1'b0; in_data[63:32] = 32'h00000022;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h00000022)
            begin n_fail++; $display("FAIL rmid_word: got v=%b d=%h expected v=1 d=00000022", out_valid, out_data); end
        rst = 1'b1;
        in_valid = '0;
        #2;
        n_checks++; if ({grant, out_valid, out_end, out_abort, busy} !== 7'b0)
            begin n_fail++; $display("FAIL rmid_async: got g=%b v=%b e=%b a=%b busy=%b expected all 0", grant, out_valid, out_end, out_abort, busy); end
        step();
        rst = 1'b0;
        req = 3'b101;
        step();
        n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL rmid_ptr_reset: got %b expected 001", grant); end
        req = '0;
        in_valid[0] = 1'b1; in_end[0] = 1'b1; in_data[31:0] = 32'h00000033;
        step();
        n_checks++; if (out_end !== 1'b1 || out_abort !== 1'b0)
            begin n_fail++; $display("FAIL rmid_after: got e=%b a=%b expected e=1 a=0", out_end, out_abort); end
        in_valid = '0; in_end = '0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_fifo_gate();
        test_timeout();
        test_stray();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
